// File: rtl/obstacle_alert_pkg.sv
// Shared encodings and width helpers for the obstacle alert arbiter slice.
// Latency: none (declarations only).
// Backpressure: none.
package obstacle_alert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALERT  = 2'd1,
        ST_LINGER = 2'd2
    } alert_state_t;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_t;

    // Width of an index selecting one of n channels (never narrower than 1 bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the values 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus stability counter for one raw sensor line.
// Latency: raw edge to level change = DEBOUNCE_CYCLES+2 clock edges.
// Backpressure: none; free-running level filter, ena low clears it.
module sensor_debounce
    import obstacle_alert_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // Synchronise the raw line, then flip the level only after enough consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else if (!ena) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/obstacle_alert_arbiter.sv
// N-channel obstacle warning: debounced sensors arbitrated onto one held one-hot alert.
// Latency: raw edge to warning = DEBOUNCE_CYCLES+3 edges; outputs registered.
// Backpressure: none; level-driven outputs, ena low clears to idle.
module obstacle_alert_arbiter
    import obstacle_alert_pkg::*;
#(
    parameter int NUM_CH          = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [NUM_CH-1:0]          sensor_in,
    input  logic                       mode_rr,
    output logic [NUM_CH-1:0]          warning,
    output logic                       alert_active,
    output logic [idx_w(NUM_CH)-1:0]   alert_idx,
    output logic [NUM_CH-1:0]          debounced
);

    localparam int IDX_W = idx_w(NUM_CH);
    localparam int HW    = cnt_w(HOLD_CYCLES);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(NUM_CH - 1);

    alert_state_t      state;
    alert_state_t      stay_state;
    arb_mode_t         mode;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_tgt;
    logic [HW-1:0]     hold_cnt;
    logic [NUM_CH-1:0] deb;
    logic [NUM_CH-1:0] grant_oh;
    logic              do_grant;
    logic              do_idle;
    logic              deb_g;
    logic              others;
    logic              preempt;

    // First set bit of v: lowest index in fixed mode, scanning from ptr+1 with wrap in round-robin.
    function automatic logic [IDX_W-1:0] sel_first(input logic [NUM_CH-1:0] v, input logic rr,
                                                   input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] r;
        logic             found;
        int               idx;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = rr ? ((int'(ptr) + 1 + k) % NUM_CH) : k;
            if (!found && v[idx]) begin
                r     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] g);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(g) == k) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic has_lower(input logic [NUM_CH-1:0] v, input logic [IDX_W-1:0] g);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k < int'(g) && v[k]) r = 1'b1;
        end
        return r;
    endfunction

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch++) begin : g_deb
            sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .ena   (ena),
                .raw   (sensor_in[ch]),
                .level (deb[ch])
            );
        end
    endgenerate

    assign debounced = deb;
    assign mode      = arb_mode_t'(mode_rr);
    assign grant_oh  = onehot(grant);
    assign deb_g     = |(deb & grant_oh);
    assign others    = |(deb & ~grant_oh);
    assign preempt   = (mode == MODE_FIXED) && has_lower(deb, grant);

    // Decide this cycle's transition: fresh grant, drop to idle, or keep the current grant.
    always_comb begin
        do_grant   = 1'b0;
        do_idle    = 1'b0;
        stay_state = state;
        grant_tgt  = sel_first(deb, mode_rr, rr_ptr);
        case (state)
            ST_IDLE: begin
                if (|deb) do_grant = 1'b1;
                else      do_idle  = 1'b1;
            end
            ST_ALERT, ST_LINGER: begin
                if (preempt) begin
                    // Lower index wins at once in fixed mode; also covers a coincident hold expiry.
                    do_grant = 1'b1;
                end else if (hold_cnt != '0) begin
                    // Hold still running: track whether the granted sensor is still asserted.
                    stay_state = deb_g ? ST_ALERT : ST_LINGER;
                end else if (!deb_g) begin
                    if (|deb) do_grant = 1'b1;
                    else      do_idle  = 1'b1;
                end else if (mode == MODE_RR && others) begin
                    grant_tgt = sel_first(deb & ~grant_oh, 1'b1, rr_ptr);
                    do_grant  = 1'b1;
                end else begin
                    stay_state = ST_ALERT;
                end
            end
            default: do_idle = 1'b1;
        endcase
    end

    // Arbiter state, hold timer and registered alert outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            grant        <= '0;
            rr_ptr       <= PTR_INIT;
            hold_cnt     <= '0;
            warning      <= '0;
            alert_active <= 1'b0;
            alert_idx    <= '0;
        end else if (!ena) begin
            state        <= ST_IDLE;
            grant        <= '0;
            rr_ptr       <= PTR_INIT;
            hold_cnt     <= '0;
            warning      <= '0;
            alert_active <= 1'b0;
            alert_idx    <= '0;
        end else if (do_grant) begin
            state        <= ST_ALERT;
            grant        <= grant_tgt;
            rr_ptr       <= grant_tgt;
            hold_cnt     <= HOLD_LAST;
            warning      <= onehot(grant_tgt);
            alert_active <= 1'b1;
            alert_idx    <= grant_tgt;
        end else if (do_idle) begin
            state        <= ST_IDLE;
            grant        <= '0;
            hold_cnt     <= '0;
            warning      <= '0;
            alert_active <= 1'b0;
            alert_idx    <= '0;
        end else begin
            state    <= stay_state;
            hold_cnt <= (hold_cnt == '0) ? '0 : hold_cnt - HW'(1);
        end
    end

endmodule

// File: tb/tb_obstacle_alert_arbiter.sv
// Directed and randomized checks of the obstacle alert arbiter against a behavioural model.
// Latency: outputs compared one half-cycle after each rising edge.
// Backpressure: not applicable.
module tb_obstacle_alert_arbiter;

    localparam int NC   = 3;
    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [NC-1:0] sensor_in;
    logic          mode_rr;
    logic [NC-1:0] warning;
    logic          alert_active;
    logic [1:0]    alert_idx;
    logic [NC-1:0] debounced;

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model state
    bit m_s1 [NC];
    bit m_s2 [NC];
    bit m_deb[NC];
    int m_run[NC];
    bit m_on;
    int m_g;
    int m_hold;
    int m_ptr;

    obstacle_alert_arbiter #(.NUM_CH(NC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .sensor_in    (sensor_in),
        .mode_rr      (mode_rr),
        .warning      (warning),
        .alert_active (alert_active),
        .alert_idx    (alert_idx),
        .debounced    (debounced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
        end
        m_on = 0; m_g = 0; m_hold = 0; m_ptr = NC - 1;
    endtask

    function automatic int pick(input int v, input bit rr, input int ptr);
        int i;
        for (int k = 0; k < NC; k++) begin
            i = rr ? (ptr + 1 + k) % NC : k;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One rising edge of the reference behaviour, using the inputs present at that edge.
    task automatic model_step();
        int dv, tgt;
        bit dg, go_idle;
        if (!rst_n || !ena) begin
            model_reset();
            return;
        end
        dv = 0;
        for (int i = 0; i < NC; i++) if (m_deb[i]) dv |= (1 << i);
        tgt = -1;
        go_idle = 0;
        if (!m_on) begin
            if (dv != 0) tgt = pick(dv, mode_rr, m_ptr);
        end else begin
            dg = dv[m_g];
            if (!mode_rr && (dv & ((1 << m_g) - 1)) != 0) tgt = pick(dv, 1'b0, m_ptr);
            else if (m_hold > 0) m_hold--;
            else if (!dg) begin
                if (dv != 0) tgt = pick(dv, mode_rr, m_ptr);
                else go_idle = 1;
            end else if (mode_rr && (dv & ~(1 << m_g)) != 0) tgt = pick(dv & ~(1 << m_g), 1'b1, m_ptr);
        end
        if (tgt >= 0) begin
            m_on = 1; m_g = tgt; m_ptr = tgt; m_hold = HOLD - 1;
        end else if (go_idle) begin
            m_on = 0; m_g = 0; m_hold = 0;
        end
        for (int i = 0; i < NC; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = !m_deb[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = sensor_in[i];
        end
    endtask

    task automatic compare_model();
        int dv;
        dv = 0;
        for (int i = 0; i < NC; i++) if (m_deb[i]) dv |= (1 << i);
        chk("warning",      32'(warning),      m_on ? (1 << m_g) : 0);
        chk("alert_active", 32'(alert_active), 32'(m_on));
        chk("alert_idx",    32'(alert_idx),    m_on ? m_g : 0);
        chk("debounced",    32'(debounced),    dv);
    endtask

    // Advance one clock edge and check every output against the model at the falling edge.
    task automatic tick();
        @(negedge clk);
        model_step();
        compare_model();
    endtask

    // Count edges until warning shows 'want'; stops at 30 so a dead design still ends.
    task automatic latency(input logic [NC-1:0] want, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (warning !== want && n < 30);
    endtask

    initial begin
        int n;
        logic [NC-1:0] seen;
        logic [NC-1:0] rot[4];
        rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100; rot[3] = 3'b001;

        rst_n = 1'b0; ena = 1'b1; sensor_in = '0; mode_rr = 1'b0;
        model_reset();
        #3;
        chk("reset_warning", 32'(warning), 0);
        chk("reset_active",  32'(alert_active), 0);
        chk("reset_idx",     32'(alert_idx), 0);
        chk("reset_deb",     32'(debounced), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // round-robin rotation from reset pointer
        mode_rr = 1'b1; sensor_in = 3'b111;
        latency(3'b001, n);
        chk("rr_first_latency", n, 7);
        for (int s = 0; s < 3; s++) begin
            n = 0;
            while (warning === rot[s] && n < 20) begin
                tick();
                n++;
            end
            chk("rr_seg_len", n, 8);
            chk("rr_next_grant", 32'(warning), 32'(rot[s + 1]));
        end

        // asynchronous reset between edges during an alert
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_warning", 32'(warning), 0);
        chk("async_rst_active",  32'(alert_active), 0);
        chk("async_rst_idx",     32'(alert_idx), 0);
        model_reset();
        tick();
        rst_n = 1'b1; mode_rr = 1'b0; sensor_in = 3'b001;

        // single channel held: first warning after 7 edges
        latency(3'b001, n);
        chk("hold_latency", n, 7);
        repeat (12) tick();

        // one cycle of ena low clears everything; full latency again
        ena = 1'b0;
        tick();
        chk("ena_clear_warning", 32'(warning), 0);
        chk("ena_clear_deb",     32'(debounced), 0);
        ena = 1'b1;
        latency(3'b001, n);
        chk("ena_relatency", n, 7);
        sensor_in = '0;
        repeat (25) tick();

        // 3-cycle glitch must not pass the debouncer
        seen = '0;
        sensor_in = 3'b010;
        repeat (3) begin tick(); seen |= warning | debounced; end
        sensor_in = '0;
        repeat (12) begin tick(); seen |= warning | debounced; end
        chk("glitch_filtered", 32'(seen), 0);

        // 6-cycle pulse stretched to exactly the hold time
        n = 0;
        sensor_in = 3'b010;
        repeat (6) begin tick(); if (warning === 3'b010) n++; end
        sensor_in = '0;
        repeat (30) begin tick(); if (warning === 3'b010) n++; end
        chk("pulse_width", n, HOLD);

        // fixed-mode preemption of ch2 by ch0
        sensor_in = 3'b100;
        repeat (10) tick();
        sensor_in = 3'b101;
        latency(3'b001, n);
        chk("preempt_latency", n, 7);
        sensor_in = '0;
        repeat (25) tick();

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 5) == 0) sensor_in[i] = ~sensor_in[i];
            if ($urandom_range(0, 49) == 0) mode_rr = ~mode_rr;
            ena = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
